adder_seq_ctrl: RTL

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_pkg.sv | 18 +
 rtl/add8_slice.sv | 28 ++
 rtl/adder_seq_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_seq_pkg : shared constants and FSM encoding for adder_seq_ctrl     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package adder_seq_pkg;

  localparam int BYTE_W         = 8;
  localparam int NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add8_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add8_slice : 8-bit ripple-carry adder slice (a + b + cin -> s, cout)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module add8_slice
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_s,
  output logic              o_cout
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_seq_ctrl : byte-serial add/sub of two NBYTES operands, one shared  |
// | 8-bit slice. Define SUB_EN to enable subtraction via op_sub.   Rev 1.0   |
// +--------------------------------------------------------------------------+
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  input  logic                     op_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int              W        = BYTE_W * NBYTES;
  localparam int              IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_work;
  logic [W-1:0]      r_sum;
  logic              r_cout;

  logic              w_accept;
  logic              w_last;
  logic              w_cin_init;
  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_s;
  logic              w_c;
  logic [W-1:0]      w_work_nxt;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];

`ifdef SUB_EN
  logic r_sub;

  // Subtract is a + ~b + 1; the forced carry replaces cin.
  assign w_b_byte   = r_b[r_idx*BYTE_W +: BYTE_W] ^ {BYTE_W{r_sub}};
  assign w_cin_init = op_sub | cin;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= op_sub;
    end
  end
`else
  logic w_unused_op_sub;

  assign w_b_byte        = r_b[r_idx*BYTE_W +: BYTE_W];
  assign w_cin_init      = cin;
  assign w_unused_op_sub = op_sub;
`endif

  add8_slice u_slice (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[r_idx*BYTE_W +: BYTE_W] = w_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= w_cin_init;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_nxt;
      r_carry <= w_c;
      if (w_last) begin
        // Result registers only change here, so sum/cout stay stable in DONE.
        r_sum  <= w_work_nxt;
        r_cout <= w_c;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
`default_nettype wire
